// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative signed/unsigned shift-add multiplier and restoring divider
module muldiv_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o,
  output logic               dbz_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, mul_next, div_next, fix_res;
  logic [WIDTH-1:0] opnd, mag1, mag2, quo, rem, rdiff;
  logic [WIDTH:0] msum, trial;
  logic [CW-1:0] cnt;
  logic is_div, sgn1, sgn2, s1, s2, accept, last, ge;
  assign accept = start_i && !cancel_i && state == IDLE;
  assign s1 = !op_i[0] && src1_i[WIDTH-1];
  assign s2 = !op_i[0] && src2_i[WIDTH-1];
  assign mag1 = s1 ? -src1_i : src1_i;
  assign mag2 = s2 ? -src2_i : src2_i;
  assign last = cnt == CW'(WIDTH - 1);
  // multiplier sits in the low half and is consumed LSB first while the product grows in the high half
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {msum, acc[WIDTH-1:1]};
  // dividend shifts out of the low half into the partial remainder; quotient bits shift in
  assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge = trial >= {1'b0, opnd};
  assign rdiff = trial[WIDTH-1:0] - opnd;
  assign div_next = {ge ? rdiff : trial[WIDTH-1:0], acc[WIDTH-2:0], ge};
  assign quo = acc[WIDTH-1:0];
  assign rem = acc[2*WIDTH-1:WIDTH];
  assign fix_res = is_div ? {(sgn1 ? -rem : rem), ((sgn1 ^ sgn2) ? -quo : quo)}
                          : ((sgn1 ^ sgn2) ? -acc : acc);
  assign busy_o = state == MUL || state == DIV || state == FIX;
  assign done_o = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !accept ? IDLE : !op_i[1] ? MUL : (src2_i == '0) ? DONE : DIV;
      MUL:     state_n = last ? FIX : MUL;
      DIV:     state_n = last ? FIX : DIV;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (cancel_i && state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state <= IDLE;
      acc <= '0;
      opnd <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      sgn1 <= 1'b0;
      sgn2 <= 1'b0;
      res_o <= '0;
      dbz_o <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        is_div <= op_i[1];
        sgn1 <= s1;
        sgn2 <= s2;
        cnt <= '0;
        opnd <= op_i[1] ? mag2 : mag1;
        acc <= {{WIDTH{1'b0}}, op_i[1] ? mag1 : mag2};
        if (op_i[1] && src2_i == '0) begin
          res_o <= {src1_i, {WIDTH{1'b1}}};
          dbz_o <= 1'b1;
        end
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + 1'b1;
        acc <= (state == MUL) ? mul_next : div_next;
      end
      if (state == FIX && !cancel_i) begin
        res_o <= fix_res;
        dbz_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: directed and random scoreboard checks of the iterative mul/div unit
module tb_muldiv_iter_unit;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] op_i = 2'b00;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic cancel_i = 1'b0;
  logic busy_o, done_o, dbz_o;
  logic [63:0] res_o;
  int total = 0;
  int bad = 0;
  logic [64:0] sb[$];
  muldiv_iter_unit #(.WIDTH(32)) dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst(cpu_rst),
    .start_i(start_i),
    .op_i(op_i),
    .src1_i(src1_i),
    .src2_i(src2_i),
    .cancel_i(cancel_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .res_o(res_o),
    .dbz_o(dbz_o)
  );
  always #10 cpu_clk_50M = ~cpu_clk_50M;
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (op[1] && b == 0) return {1'b1, a, 32'hFFFFFFFF};
    case (op)
      2'b00: p = sa * sb2;
      2'b01: p = ua * ub;
      2'b10: p = {32'(sa % sb2), 32'(sa / sb2)};
      default: p = {a % b, a / b};
    endcase
    return {1'b0, p};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, output int waits);
    op_i = op;
    src1_i = a;
    src2_i = b;
    start_i = 1'b1;
    if (push) sb.push_back(model(op, a, b));
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!(busy_o || done_o) && waits < 10);
    start_i = 1'b0;
  endtask
  task automatic finish_op(input int lat0, input int exp_lat, input string tag);
    int lat, bc;
    logic [64:0] e;
    lat = lat0;
    bc = busy_o ? lat0 : 0;
    while (!done_o && lat < 200) begin
      tick();
      lat++;
      if (busy_o) bc++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk({tag, " res"}, res_o, e[63:0]);
    chk({tag, " dbz"}, 64'(dbz_o), 64'(e[64]));
  endtask
  task automatic after_done(input string tag);
    tick();
    chk({tag, " done_pulse"}, 64'({done_o, busy_o}), 64'(0));
  endtask
  initial begin
    int w, dn;
    logic [63:0] keep;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    repeat (2) tick();
    chk("reset", {res_o[61:0], busy_o, done_o}, 64'(0));
    chk("reset dbz", 64'(dbz_o), 64'(0));
    cpu_rst = 1'b0;
    tick();
    start_op(2'b00, 32'hFFFFFFFE, 32'h3, 1, w);
    finish_op(1, 34, "mult");
    chk("mult const", res_o, 64'hFFFFFFFF_FFFFFFFA);
    after_done("mult");
    start_op(2'b01, 32'hFFFFFFFE, 32'h3, 1, w);
    start_i = 1'b1;
    op_i = 2'b11;
    src2_i = '0;
    repeat (5) tick();
    start_i = 1'b0;
    finish_op(6, 34, "multu_start_busy");
    chk("multu const", res_o, 64'h00000002_FFFFFFFA);
    after_done("multu");
    start_op(2'b10, 32'hFFFFFFF9, 32'h2, 1, w);
    finish_op(1, 34, "div_m7_2");
    chk("div const", res_o, 64'hFFFFFFFF_FFFFFFFD);
    after_done("div");
    start_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1, w);
    finish_op(1, 34, "divu_big");
    chk("divu const", res_o, 64'h80000000_00000000);
    after_done("divu");
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, w);
    finish_op(1, 34, "div_ovf");
    chk("div_ovf const", res_o, 64'h00000000_80000000);
    after_done("div_ovf");
    start_op(2'b11, 32'h1234, 32'h0, 1, w);
    finish_op(1, 1, "divu_dbz");
    chk("dbz const", res_o, 64'h00001234_FFFFFFFF);
    after_done("dbz");
    keep = res_o;
    start_op(2'b00, 32'h5, 32'h7, 0, w);
    repeat (10) tick();
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    chk("cancel busy", 64'(busy_o), 64'(0));
    dn = 0;
    repeat (40) begin
      tick();
      if (done_o) dn++;
    end
    chk("cancel no_done", 64'(dn), 64'(0));
    chk("cancel res_kept", res_o, keep);
    chk("cancel dbz_kept", 64'(dbz_o), 64'(1));
    op_i = 2'b10;
    src1_i = 32'd100;
    src2_i = 32'd7;
    start_i = 1'b1;
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    chk("start_cancel ignored", 64'({busy_o, done_o}), 64'(0));
    tick();
    start_i = 1'b0;
    chk("start after cancel", 64'(busy_o), 64'(1));
    sb.push_back(model(2'b10, 32'd100, 32'd7));
    finish_op(1, 34, "div_100_7");
    after_done("div_100_7");
    start_op(2'b10, 32'h12345678, 32'h9, 0, w);
    repeat (5) tick();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    chk("rst_mid res", res_o, 64'(0));
    chk("rst_mid flags", 64'({busy_o, done_o, dbz_o}), 64'(0));
    dn = 0;
    repeat (40) begin
      tick();
      if (done_o || busy_o) dn++;
    end
    chk("rst_mid idle", 64'(dn), 64'(0));
    start_op(2'b01, 32'hDEADBEEF, 32'h10, 1, w);
    finish_op(1, 34, "b2b_first");
    start_op(2'b00, 32'h80000000, 32'h80000000, 1, w);
    chk("b2b accept_edge", 64'(w), 64'(2));
    finish_op(1, 34, "b2b_second");
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(0, 31);
      start_op(rop, ra, rb, 1, w);
      finish_op(1, (rop[1] && rb == 0) ? 1 : 34, $sformatf("rand%0d", i));
    end
    after_done("rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
